// File: rtl/d_mem_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes, FSM states
// and the wait-state counter width.
package d_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/d_mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// alignment check, and load lane extraction with sign/zero extension.
module d_mem_lane_align
  import d_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    store_data = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = rword[7:0];
    case (addr_lo)
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      2'd3: byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // A word load returns the raw word; unsigned only matters for sub-word sizes.
  always_comb begin
    load_data = rword;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/d_memory_be.sv
// Byte-addressed data memory with req/ready/valid handshake, programmable
// wait states and error flagging for misaligned or out-of-range accesses.
module d_memory_be
  import d_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output state_e      state_dbg_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request is accepted on a rising edge where req_i && ready_o;
  // ready_o is high only in IDLE and does not depend on req_i. The response is
  // a single-cycle valid_o pulse, with rdata_o/err_o meaningful only then.
  // There is no backpressure on the response and requests seen while busy are
  // dropped, not queued.
  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, commit;

  logic             we_q, uns_q;
  logic [31:0]      addr_q, wdata_q;
  logic [1:0]       size_q;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [AW-1:0]    idx;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      store_data, load_data;
  logic             misaligned, range_err, access_err;

  assign ready_o     = (state == IDLE);
  assign accept      = req_i && ready_o;
  assign commit      = (state == BUSY) && (cnt == '0);
  assign state_dbg_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
    end else if (accept) begin
      we_q    <= we_i;
      uns_q   <= unsigned_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      size_q  <= size_i;
    end
  end

  // Any address bit above the word index makes the access out of range.
  assign range_err  = (addr_q >> (AW + 2)) != 32'd0;
  assign access_err = misaligned || range_err;
  assign idx        = addr_q[AW+1:2];
  assign rword      = mem[idx];

  d_mem_lane_align u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .wdata      (wdata_q),
    .rword      (rword),
    .be         (be),
    .store_data (store_data),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  // Reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && we_q && !access_err) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= store_data[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      valid_o <= commit;
      if (commit) begin
        err_o   <= access_err;
        rdata_o <= (access_err || we_q) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_d_memory_be.sv
// Directed bench for d_memory_be: one instance with no wait states and one with
// three, responses checked against an expected queue filled at drive time.
module tb_d_memory_be;
  import d_mem_pkg::*;

  logic        clk;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  state_e      st    [2];

  logic [32:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  d_memory_be #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .size_i(size[0]), .unsigned_i(uns[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
    .valid_o(valid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .state_dbg_o(st[0])
  );

  d_memory_be #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .size_i(size[1]), .unsigned_i(uns[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
    .valid_o(valid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .state_dbg_o(st[1])
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for its response and score it.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd, input int lat,
                        input string tag);
    int          cyc;
    logic [32:0] e;
    exp_q.push_back({e_err, e_rd});
    @(negedge clk);
    we[d] = w; addr[d] = a; size[d] = sz; uns[d] = u; wdata[d] = wd; req[d] = 1'b1;
    check({tag, "_ready"}, 64'(ready[d]), 64'd1);
    @(posedge clk); #1;
    req[d] = 1'b0;
    cyc = 0;
    while (valid[d] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    e = exp_q.pop_front();
    check({tag, "_resp"}, 64'({err[d], rdata[d]}), 64'(e));
  endtask

  task automatic idle_no_valid(input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(tag, 64'(valid[d]), 64'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
      size[d] = SZ_WORD; uns[d] = 1'b0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 64'(ready[d]), 64'd1);
      check("rst_valid", 64'(valid[d]), 64'd0);
      check("rst_err",   64'(err[d]),   64'd0);
      check("rst_rdata", 64'(rdata[d]), 64'd0);
      check("rst_state", 64'(st[d]),    64'(IDLE));
    end

    // Zero wait states: stores, loads, lane merging and extension
    access(0, 1, 32'h10, SZ_WORD, 0, 32'hDEADBEEF, 0, 32'h0,        1, "st_word");
    access(0, 0, 32'h10, SZ_WORD, 0, 32'h0,        0, 32'hDEADBEEF, 1, "ld_word");
    access(0, 1, 32'h11, SZ_BYTE, 0, 32'hFFFFFF5A, 0, 32'h0,        1, "st_byte");
    access(0, 0, 32'h10, SZ_WORD, 1, 32'h0,        0, 32'hDEAD5AEF, 1, "ld_merge");
    access(0, 0, 32'h13, SZ_BYTE, 0, 32'h0,        0, 32'hFFFFFFDE, 1, "ld_b_s");
    access(0, 0, 32'h13, SZ_BYTE, 1, 32'h0,        0, 32'h000000DE, 1, "ld_b_u");
    access(0, 0, 32'h11, SZ_BYTE, 0, 32'h0,        0, 32'h0000005A, 1, "ld_b1_s");
    access(0, 0, 32'h12, SZ_HALF, 0, 32'h0,        0, 32'hFFFFDEAD, 1, "ld_h_s");
    access(0, 0, 32'h12, SZ_HALF, 1, 32'h0,        0, 32'h0000DEAD, 1, "ld_h_u");
    access(0, 0, 32'h10, SZ_HALF, 0, 32'h0,        0, 32'h00005AEF, 1, "ld_h0_s");

    // Rejected accesses leave memory untouched
    access(0, 1, 32'h11,  SZ_HALF, 0, 32'h0000FFFF, 1, 32'h0, 1, "err_st_half");
    access(0, 0, 32'h12,  SZ_WORD, 0, 32'h0,        1, 32'h0, 1, "err_ld_word");
    access(0, 1, 32'h10,  SZ_ILL,  0, 32'h12345678, 1, 32'h0, 1, "err_st_ill");
    access(0, 0, 32'h10,  SZ_ILL,  0, 32'h0,        1, 32'h0, 1, "err_ld_ill");
    access(0, 1, 32'h400, SZ_WORD, 0, 32'h0BADF00D, 1, 32'h0, 1, "err_st_range");
    access(0, 0, 32'h400, SZ_WORD, 0, 32'h0,        1, 32'h0, 1, "err_ld_range");
    access(0, 1, 32'h80000010, SZ_BYTE, 0, 32'h77,  1, 32'h0, 1, "err_st_hi");
    access(0, 0, 32'h10,  SZ_WORD, 0, 32'h0,        0, 32'hDEAD5AEF, 1, "ld_unchanged");
    access(0, 1, 32'h12,  SZ_HALF, 0, 32'hAAAA1234, 0, 32'h0, 1, "st_half_hi");
    access(0, 0, 32'h10,  SZ_WORD, 0, 32'h0,        0, 32'h12345AEF, 1, "ld_half_merge");
    access(0, 1, 32'h3FC, SZ_WORD, 0, 32'hA5A55A5A, 0, 32'h0, 1, "st_top");
    access(0, 0, 32'h3FF, SZ_BYTE, 0, 32'h0,        0, 32'hFFFFFFA5, 1, "ld_top_b");

    // Three wait states: busy window, ignored requests, fields latched at accept
    exp_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    we[1] = 1'b1; addr[1] = 32'h20; size[1] = SZ_WORD; uns[1] = 1'b0;
    wdata[1] = 32'hCAFEF00D; req[1] = 1'b1;
    check("ws3_accept_ready", 64'(ready[1]), 64'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("ws3_busy_ready", 64'(ready[1]), 64'd0);
      check("ws3_busy_valid", 64'(valid[1]), 64'd0);
      if (c <= 2) begin
        we[1] = 1'b0; addr[1] = 32'h24; wdata[1] = 32'h0; req[1] = 1'b1;
      end else begin
        req[1] = 1'b0;
      end
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    check("ws3_valid",      64'(valid[1]), 64'd1);
    check("ws3_valid_ready", 64'(ready[1]), 64'd1);
    begin
      logic [32:0] e;
      e = exp_q.pop_front();
      check("ws3_resp", 64'({err[1], rdata[1]}), 64'(e));
    end
    idle_no_valid(1, 6, "ws3_no_extra_valid");
    access(1, 0, 32'h20, SZ_WORD, 0, 32'h0, 0, 32'hCAFEF00D, 4, "ws3_ld");

    // Reset two cycles after accept drops the pending store
    @(negedge clk);
    we[1] = 1'b1; addr[1] = 32'h20; size[1] = SZ_WORD; wdata[1] = 32'h11223344; req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    check("rstmid_busy", 64'(ready[1]), 64'd0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("rstmid_valid", 64'(valid[1]), 64'd0);
    check("rstmid_ready", 64'(ready[1]), 64'd1);
    check("rstmid_state", 64'(st[1]),    64'(IDLE));
    idle_no_valid(1, 8, "rstmid_no_valid");
    access(1, 0, 32'h20, SZ_WORD, 0, 32'h0, 0, 32'hCAFEF00D, 4, "rstmid_ld");
    access(1, 0, 32'h21, SZ_HALF, 0, 32'h0, 1, 32'h0,        4, "ws3_err");

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
